// File: rtl/counter_pkg.sv
// Shared types and constants for the multi-lane counter pattern source.
package counter_pkg;

    typedef enum logic [1:0] {
        INIT_ST = 2'd0,
        WAIT_ST = 2'd1,
        RUN_ST  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_FREE  = 2'd0;
    localparam logic [1:0] MODE_WAIT  = 2'd1;
    localparam logic [1:0] MODE_BURST = 2'd2;
    localparam logic [1:0] MODE_RSVD  = 2'd3;

    // The reserved mode code behaves exactly like free-run.
    function automatic logic [1:0] eff_mode(input logic [1:0] mode);
        return (mode == MODE_RSVD) ? MODE_FREE : mode;
    endfunction

endpackage

// File: rtl/synchronizer_n.sv
// Multi-flop synchroniser bringing a slow asynchronous level into the clock domain.
// STAGES must be at least 2.
module synchronizer_n #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic aresetn,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous level through the flop chain; the last flop is the safe copy.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
        end
    end

    assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/counter_nch.sv
// Multi-lane AXI4-Stream test-pattern source: NCH lanes of stepped counter data per beat,
// a beat counter on tuser and tlast framing in burst mode, paced by a small INIT/WAIT/RUN FSM.
module counter_nch
    import counter_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int BDATA = 16,
    parameter int BUSER = 8
) (
    input  logic                   m_axis_aclk,
    input  logic                   m_axis_aresetn,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [NCH*BDATA-1:0]   m_axis_tdata,
    output logic [BUSER-1:0]       m_axis_tuser,
    output logic                   m_axis_tlast,
    input  logic                   START_REG,
    input  logic [1:0]             MODE_REG,
    input  logic [31:0]            NDATA_REG,
    input  logic [31:0]            NUSER_REG,
    input  logic [31:0]            WAIT_REG,
    input  logic [BDATA-1:0]       STEP_REG,
    input  logic [31:0]            NBURST_REG
);

    state_t             state;
    logic               start_rs;
    logic               tvalid_r;

    logic [1:0]         mode_r;
    logic [31:0]        ndata_r;
    logic [31:0]        nuser_r;
    logic [31:0]        wait_r;
    logic [BDATA-1:0]   step_r;
    logic [31:0]        nburst_r;

    logic [BDATA-1:0]   cnt_data;
    logic [BUSER-1:0]   cnt_user;
    logic [31:0]        cnt_wait;
    logic [31:0]        cnt_burst;

    logic               handshake;
    logic [1:0]         mode_eff;
    logic [31:0]        burst_last;
    logic               burst_end;
    logic [32:0]        data_sum;
    logic [BDATA-1:0]   data_nxt;
    logic [31:0]        user_ext;
    logic [BUSER-1:0]   user_nxt;

    synchronizer_n #(
        .STAGES (2)
    ) u_start_sync (
        .clk     (m_axis_aclk),
        .aresetn (m_axis_aresetn),
        .din     (START_REG),
        .dout    (start_rs)
    );

    assign handshake  = tvalid_r & m_axis_tready;
    assign mode_eff   = eff_mode(mode_r);
    assign burst_last = (nburst_r == 32'd0) ? 32'd0 : nburst_r - 32'd1;
    assign burst_end  = (cnt_burst == burst_last);

    // The wide sum keeps a carry so the modulus compare also works when NDATA exceeds 2^BDATA.
    assign data_sum = 33'(cnt_data) + 33'(NCH) * 33'(step_r);
    assign data_nxt = ((ndata_r != 32'd0) && (data_sum >= {1'b0, ndata_r})) ? '0 : data_sum[BDATA-1:0];

    assign user_ext = 32'(cnt_user);
    assign user_nxt = ((nuser_r != 32'd0) && (user_ext == nuser_r - 32'd1)) ? '0 : cnt_user + BUSER'(1);

    // Configuration shadows follow the registers while stopped and freeze once the run starts.
    always_ff @(posedge m_axis_aclk) begin
        if (!m_axis_aresetn) begin
            mode_r   <= '0;
            ndata_r  <= '0;
            nuser_r  <= '0;
            wait_r   <= '0;
            step_r   <= '0;
            nburst_r <= '0;
        end else if (!start_rs) begin
            mode_r   <= MODE_REG;
            ndata_r  <= NDATA_REG;
            nuser_r  <= NUSER_REG;
            wait_r   <= WAIT_REG;
            step_r   <= STEP_REG;
            nburst_r <= NBURST_REG;
        end
    end

    // Pacing FSM with registered tvalid; counters only move on an accepted beat, so a stalled beat holds.
    always_ff @(posedge m_axis_aclk) begin
        if (!m_axis_aresetn) begin
            state     <= INIT_ST;
            tvalid_r  <= 1'b0;
            cnt_data  <= '0;
            cnt_user  <= '0;
            cnt_wait  <= '0;
            cnt_burst <= '0;
        end else begin
            case (state)
                INIT_ST: begin
                    if (start_rs) begin
                        cnt_data  <= '0;
                        cnt_user  <= '0;
                        cnt_wait  <= '0;
                        cnt_burst <= '0;
                        if ((mode_eff != MODE_FREE) && (wait_r != 32'd0)) begin
                            state <= WAIT_ST;
                        end else begin
                            state    <= RUN_ST;
                            tvalid_r <= 1'b1;
                        end
                    end
                end
                WAIT_ST: begin
                    if (!start_rs) begin
                        state    <= INIT_ST;
                        cnt_wait <= '0;
                    end else if (cnt_wait == wait_r - 32'd1) begin
                        cnt_wait <= '0;
                        state    <= RUN_ST;
                        tvalid_r <= 1'b1;
                    end else begin
                        cnt_wait <= cnt_wait + 32'd1;
                    end
                end
                RUN_ST: begin
                    if (handshake) begin
                        cnt_data  <= data_nxt;
                        cnt_user  <= user_nxt;
                        cnt_burst <= burst_end ? 32'd0 : cnt_burst + 32'd1;
                        if (!start_rs) begin
                            state    <= INIT_ST;
                            tvalid_r <= 1'b0;
                        end else if ((mode_eff == MODE_WAIT) && (wait_r != 32'd0)) begin
                            state    <= WAIT_ST;
                            tvalid_r <= 1'b0;
                        end else if ((mode_eff == MODE_BURST) && burst_end && (wait_r != 32'd0)) begin
                            state    <= WAIT_ST;
                            tvalid_r <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= INIT_ST;
                    tvalid_r <= 1'b0;
                end
            endcase
        end
    end

    // Each lane is the shared base plus a fixed multiple of the step, wrapping naturally.
    for (genvar k = 0; k < NCH; k++) begin : g_lane
        localparam logic [BDATA-1:0] LANE_K = BDATA'(k);
        assign m_axis_tdata[k*BDATA +: BDATA] = cnt_data + LANE_K * step_r;
    end

    assign m_axis_tvalid = tvalid_r;
    assign m_axis_tuser  = cnt_user;
    assign m_axis_tlast  = tvalid_r && (mode_eff == MODE_BURST) && burst_end;

endmodule

// File: tb/tb_counter_nch.sv
// Self-checking bench for counter_nch: table vectors, random configurations and
// hand-written stop/restart/reset sequences against a beat-level reference model.
module tb_counter_nch;

    localparam int NCH   = 4;
    localparam int BDATA = 16;
    localparam int BUSER = 8;

    logic                 m_axis_aclk = 1'b0;
    logic                 m_axis_aresetn;
    logic                 m_axis_tvalid;
    logic                 m_axis_tready;
    logic [NCH*BDATA-1:0] m_axis_tdata;
    logic [BUSER-1:0]     m_axis_tuser;
    logic                 m_axis_tlast;
    logic                 start_reg;
    logic [1:0]           mode_reg;
    logic [31:0]          ndata_reg;
    logic [31:0]          nuser_reg;
    logic [31:0]          wait_reg;
    logic [BDATA-1:0]     step_reg;
    logic [31:0]          nburst_reg;

    typedef struct {
        logic [1:0]  mode;
        int          ndata;
        int          nuser;
        int          wait_cyc;
        int          nburst;
        logic [15:0] step;
        int          nbeats;
        int          ready_pct;
        int          chk_idx;
        logic [15:0] chk_lane0;
        logic [15:0] chk_lane_hi;
        logic [7:0]  chk_user;
        logic        chk_last;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // reference model state: beat index and base value of the next beat
    int              m_mode;
    longint unsigned m_ndata;
    int              m_nuser;
    int              m_wait;
    int              m_nburst;
    longint unsigned m_step;
    longint unsigned m_base;
    int              m_n;

    // run bookkeeping
    int                   got;
    int                   cyc;
    int                   last_cyc;
    bit                   prev_stall;
    logic [NCH*BDATA-1:0] p_data;
    logic [BUSER-1:0]     p_user;
    logic                 p_last;
    int                   ready_pct;
    bit                   gap_en;
    bit                   chk_en;
    vec_t                 cur;

    counter_nch #(
        .NCH   (NCH),
        .BDATA (BDATA),
        .BUSER (BUSER)
    ) dut (
        .m_axis_aclk    (m_axis_aclk),
        .m_axis_aresetn (m_axis_aresetn),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tuser   (m_axis_tuser),
        .m_axis_tlast   (m_axis_tlast),
        .START_REG      (start_reg),
        .MODE_REG       (mode_reg),
        .NDATA_REG      (ndata_reg),
        .NUSER_REG      (nuser_reg),
        .WAIT_REG       (wait_reg),
        .STEP_REG       (step_reg),
        .NBURST_REG     (nburst_reg)
    );

    always #5 m_axis_aclk = ~m_axis_aclk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    function automatic logic [NCH*BDATA-1:0] exp_data();
        logic [NCH*BDATA-1:0] d;
        longint unsigned      v;
        d = '0;
        for (int k = 0; k < NCH; k++) begin
            v = m_base + longint'(k) * m_step;
            d[k*BDATA +: BDATA] = v[BDATA-1:0];
        end
        return d;
    endfunction

    function automatic int burst_len();
        return (m_nburst == 0) ? 1 : m_nburst;
    endfunction

    function automatic int exp_user();
        int nu;
        nu = (m_nuser == 0) ? 256 : m_nuser;
        return m_n % nu;
    endfunction

    function automatic logic exp_last();
        return (m_mode == 2) && ((m_n % burst_len()) == burst_len() - 1);
    endfunction

    function automatic int exp_gap();
        if (m_mode == 1 && m_wait != 0) return m_wait + 1;
        if (m_mode == 2 && m_wait != 0 && (m_n % burst_len()) == 0) return m_wait + 1;
        return 1;
    endfunction

    task automatic model_advance();
        longint unsigned nxt;
        nxt = m_base + longint'(NCH) * m_step;
        if (m_ndata != 0 && nxt >= m_ndata) m_base = 0;
        else m_base = nxt % 65536;
        m_n++;
    endtask

    // one cycle: pick tready for the coming edge, then judge the beat it will accept
    task automatic stepCycle();
        @(negedge m_axis_aclk);
        cyc++;
        if (prev_stall) begin
            checkOutput("hold_valid", 64'(m_axis_tvalid), 64'd1);
            checkOutput("hold_data", m_axis_tdata, p_data);
            checkOutput("hold_user", 64'(m_axis_tuser), 64'(p_user));
            checkOutput("hold_last", 64'(m_axis_tlast), 64'(p_last));
        end
        m_axis_tready = ($urandom_range(0, 99) < ready_pct);
        if (m_axis_tvalid && m_axis_tready) begin
            checkOutput("beat_data", m_axis_tdata, exp_data());
            checkOutput("beat_user", 64'(m_axis_tuser), 64'(exp_user()));
            checkOutput("beat_last", 64'(m_axis_tlast), 64'(exp_last()));
            if (gap_en && m_n > 0)
                checkOutput("beat_gap", 64'(cyc - last_cyc), 64'(exp_gap()));
            if (chk_en && m_n == cur.chk_idx) begin
                checkOutput("tbl_lane0", 64'(m_axis_tdata[BDATA-1:0]), 64'(cur.chk_lane0));
                checkOutput("tbl_lane_hi", 64'(m_axis_tdata[(NCH-1)*BDATA +: BDATA]), 64'(cur.chk_lane_hi));
                checkOutput("tbl_user", 64'(m_axis_tuser), 64'(cur.chk_user));
                checkOutput("tbl_last", 64'(m_axis_tlast), 64'(cur.chk_last));
            end
            last_cyc = cyc;
            model_advance();
            got++;
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        p_data = m_axis_tdata;
        p_user = m_axis_tuser;
        p_last = m_axis_tlast;
    endtask

    task automatic applyStimulus(input vec_t v, input bit use_table);
        @(negedge m_axis_aclk);
        start_reg     = 1'b0;
        m_axis_tready = 1'b0;
        mode_reg      = v.mode;
        ndata_reg     = v.ndata;
        nuser_reg     = v.nuser;
        wait_reg      = v.wait_cyc;
        step_reg      = v.step;
        nburst_reg    = v.nburst;
        repeat (6) @(negedge m_axis_aclk);
        m_mode   = (v.mode == 2'd3) ? 0 : int'(v.mode);
        m_ndata  = longint'(v.ndata);
        m_nuser  = v.nuser;
        m_wait   = v.wait_cyc;
        m_nburst = v.nburst;
        m_step   = longint'(v.step);
        m_base   = 0;
        m_n      = 0;
        got = 0; cyc = 0; last_cyc = 0; prev_stall = 1'b0;
        ready_pct = v.ready_pct;
        gap_en    = (v.ready_pct == 100);
        chk_en    = use_table;
        cur       = v;
        start_reg = 1'b1;
        while (got < v.nbeats && cyc < 2000) stepCycle();
        if (got < v.nbeats) checkOutput("beat_timeout", 64'(got), 64'(v.nbeats));
        start_reg = 1'b0;
        gap_en    = 1'b0;
        chk_en    = 1'b0;
        ready_pct = 100;
        repeat (10) stepCycle();
        @(negedge m_axis_aclk);
        checkOutput("stop_idle_valid", 64'(m_axis_tvalid), 64'd0);
    endtask

    initial begin
        vec_t vecs[8];
        vec_t rv;
        int   n;
        logic [NCH*BDATA-1:0] held;

        vecs[0] = '{2'd0, 16, 0, 0, 0, 16'h0001, 10, 100, 4, 16'h0000, 16'h0003, 8'd4, 1'b0};
        vecs[1] = '{2'd1, 0,  3, 3, 0, 16'h0001, 8,  100, 4, 16'h0010, 16'h0013, 8'd1, 1'b0};
        vecs[2] = '{2'd2, 0,  0, 2, 4, 16'h0001, 12, 100, 3, 16'h000C, 16'h000F, 8'd3, 1'b1};
        vecs[3] = '{2'd1, 0,  0, 0, 0, 16'hFFFF, 8,  100, 2, 16'hFFF8, 16'hFFF5, 8'd2, 1'b0};
        vecs[4] = '{2'd2, 0,  0, 0, 0, 16'hFFFF, 6,  100, 1, 16'hFFFC, 16'hFFF9, 8'd1, 1'b1};
        vecs[5] = '{2'd2, 20, 5, 1, 3, 16'h0002, 10, 60,  4, 16'h0008, 16'h000E, 8'd4, 1'b0};
        vecs[6] = '{2'd3, 0,  0, 0, 0, 16'h0003, 12, 50,  2, 16'h0018, 16'h0021, 8'd2, 1'b0};
        vecs[7] = '{2'd1, 100, 7, 2, 0, 16'h0005, 10, 70, 5, 16'h0000, 16'h000F, 8'd5, 1'b0};

        m_axis_aresetn = 1'b0;
        m_axis_tready  = 1'b0;
        start_reg      = 1'b0;
        mode_reg       = 2'd0;
        ndata_reg      = 32'd0;
        nuser_reg      = 32'd0;
        wait_reg       = 32'd0;
        step_reg       = 16'h0005;
        nburst_reg     = 32'd0;
        repeat (4) @(negedge m_axis_aclk);
        checkOutput("reset_valid", 64'(m_axis_tvalid), 64'd0);
        checkOutput("reset_last", 64'(m_axis_tlast), 64'd0);
        checkOutput("reset_user", 64'(m_axis_tuser), 64'd0);
        checkOutput("reset_data", m_axis_tdata, 64'd0);
        m_axis_aresetn = 1'b1;

        $display("[TB] table vectors");
        for (int i = 0; i < 8; i++) applyStimulus(vecs[i], 1'b1);

        $display("[TB] random configurations");
        for (int i = 0; i < 4; i++) begin
            rv.mode      = 2'($urandom_range(0, 3));
            rv.ndata     = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 300)) : 0;
            rv.nuser     = int'($urandom_range(0, 9));
            rv.wait_cyc  = int'($urandom_range(0, 3));
            rv.nburst    = int'($urandom_range(0, 5));
            rv.step      = 16'($urandom_range(0, 65535));
            rv.nbeats    = 12;
            rv.ready_pct = int'($urandom_range(40, 100));
            rv.chk_idx   = 0;
            rv.chk_lane0 = '0; rv.chk_lane_hi = '0; rv.chk_user = '0; rv.chk_last = 1'b0;
            applyStimulus(rv, 1'b0);
        end

        $display("[TB] stop while stalled, then restart");
        mode_reg = 2'd0; ndata_reg = 32'd0; nuser_reg = 32'd0;
        wait_reg = 32'd0; step_reg = 16'h0001; nburst_reg = 32'd0;
        repeat (6) @(negedge m_axis_aclk);
        start_reg     = 1'b1;
        m_axis_tready = 1'b1;
        n = 0;
        for (int c = 0; c < 50 && n < 3; c++) begin
            @(negedge m_axis_aclk);
            if (m_axis_tvalid) n++;
        end
        checkOutput("stop_pre_beats", 64'(n), 64'd3);
        @(negedge m_axis_aclk);
        m_axis_tready = 1'b0;
        checkOutput("stop_pending_lane0", 64'(m_axis_tdata[BDATA-1:0]), 64'd12);
        held      = m_axis_tdata;
        start_reg = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge m_axis_aclk);
            checkOutput("stop_hold_valid", 64'(m_axis_tvalid), 64'd1);
            checkOutput("stop_hold_data", m_axis_tdata, held);
        end
        @(negedge m_axis_aclk);
        m_axis_tready = 1'b1;
        @(negedge m_axis_aclk);
        m_axis_tready = 1'b0;
        checkOutput("stop_after_valid", 64'(m_axis_tvalid), 64'd0);
        start_reg = 1'b1;
        n = 0;
        while (!m_axis_tvalid && n < 20) begin
            @(negedge m_axis_aclk);
            n++;
        end
        checkOutput("restart_valid", 64'(m_axis_tvalid), 64'd1);
        checkOutput("restart_lane0", 64'(m_axis_tdata[BDATA-1:0]), 64'd0);
        checkOutput("restart_user", 64'(m_axis_tuser), 64'd0);

        $display("[TB] reset mid-beat");
        @(negedge m_axis_aclk);
        m_axis_aresetn = 1'b0;
        @(negedge m_axis_aclk);
        checkOutput("midreset_valid", 64'(m_axis_tvalid), 64'd0);
        checkOutput("midreset_data", m_axis_tdata, 64'd0);
        checkOutput("midreset_user", 64'(m_axis_tuser), 64'd0);
        start_reg = 1'b0;
        @(negedge m_axis_aclk);
        m_axis_aresetn = 1'b1;
        repeat (2) @(negedge m_axis_aclk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
